// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the writeback stage: result-source select,
// stage state encoding and RISC-V load funct3 codes.
package rv_wb_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } wb_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: picks the byte/half lane from the
// response word and sign- or zero-extends it according to funct3.
module load_align
   import rv_wb_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word[7:0];
      case (addr_lo)
         2'd0: byte_lane = word[7:0];
         2'd1: byte_lane = word[15:8];
         2'd2: byte_lane = word[23:16];
         2'd3: byte_lane = word[31:24];
         default: byte_lane = word[7:0];
      endcase
      // Halves are lane-selected by bit 1 only; misalignment is not our concern.
      half_lane = addr_lo[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      result = word;
      case (funct3)
         F3_LB:   result = {{24{byte_lane[7]}}, byte_lane};
         F3_LH:   result = {{16{half_lane[15]}}, half_lane};
         F3_LBU:  result = {24'd0, byte_lane};
         F3_LHU:  result = {16'd0, half_lane};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for the load response
// if needed, and drives the register file write port. Optional read-port
// bypass of the value being written is enabled by defining WB_BYPASS_EN.
//
// Handshake: an instruction transfers on a rising edge where valid_i && ready_o;
// valid_i may be held or dropped freely while ready_o is low.
module wb_stage
   import rv_wb_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [4:0]  rd_i,
   input  logic        reg_wen_i,
   input  logic [1:0]  wb_sel_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] alu_i,
   input  logic [31:0] pc4_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        reg_wen_o,
   output logic [4:0]  reg_waddr_o,
   output logic [31:0] reg_wdata_o,
   output logic        retire_o,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] rf_data1_i,
   input  logic [31:0] rf_data2_i,
   output logic [31:0] data1_o,
   output logic [31:0] data2_o,
   output wb_state_e   state_o
);

   wb_state_e   state_q, state_d;
   logic [4:0]  rd_q;
   logic        reg_wen_q;
   logic [1:0]  wb_sel_q;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;
   logic [31:0] alu_q;
   logic [31:0] pc4_q;
   logic [31:0] rdata_q;
   logic [31:0] load_data;
   logic        accept;

   assign ready_o = (state_q != WAIT_MEM);
   assign accept  = valid_i && ready_o;
   assign state_o = state_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rd_q      <= 5'd0;
         reg_wen_q <= 1'b0;
         wb_sel_q  <= 2'd0;
         funct3_q  <= 3'd0;
         addr_lo_q <= 2'd0;
         alu_q     <= 32'd0;
         pc4_q     <= 32'd0;
         rdata_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rd_q      <= rd_i;
            reg_wen_q <= reg_wen_i;
            wb_sel_q  <= wb_sel_i;
            funct3_q  <= funct3_i;
            addr_lo_q <= addr_lo_i;
            alu_q     <= alu_i;
            pc4_q     <= pc4_i;
         end
         if (state_q == WAIT_MEM && dmem_rvalid_i) begin
            rdata_q <= dmem_rdata_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, WRITE: begin
            if (accept) state_d = (wb_sel_i == WB_MEM) ? WAIT_MEM : WRITE;
            else        state_d = IDLE;
         end
         WAIT_MEM: if (dmem_rvalid_i) state_d = WRITE;
         default:  state_d = IDLE;
      endcase
   end

   load_align u_load_align (
      .word    (rdata_q),
      .funct3  (funct3_q),
      .addr_lo (addr_lo_q),
      .result  (load_data)
   );

   always_comb begin
      reg_wen_o   = 1'b0;
      reg_waddr_o = 5'd0;
      reg_wdata_o = 32'd0;
      retire_o    = 1'b0;
      if (state_q == WRITE) begin
         retire_o    = 1'b1;
         reg_wen_o   = reg_wen_q && (rd_q != 5'd0);
         reg_waddr_o = rd_q;
         // Select code 3 is reserved and falls back to the ALU result.
         case (wb_sel_q)
            WB_MEM:  reg_wdata_o = load_data;
            WB_PC4:  reg_wdata_o = pc4_q;
            default: reg_wdata_o = alu_q;
         endcase
      end
   end

`ifdef WB_BYPASS_EN
   always_comb begin
      data1_o = rf_data1_i;
      data2_o = rf_data2_i;
      if (reg_wen_o && rs1_i == reg_waddr_o && rs1_i != 5'd0) data1_o = reg_wdata_o;
      if (reg_wen_o && rs2_i == reg_waddr_o && rs2_i != 5'd0) data2_o = reg_wdata_o;
   end
`else
   logic unused_rs;
   assign unused_rs = ^{rs1_i, rs2_i};
   assign data1_o   = rf_data1_i;
   assign data2_o   = rf_data2_i;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: ALU/PC4/load writes, back-to-back issue,
// rd=0 suppression, reset mid-load and read-port bypass (WB_BYPASS_EN aware).
module tb_wb_stage;
   import rv_wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        ready_o;
   logic [4:0]  rd_i;
   logic        reg_wen_i;
   logic [1:0]  wb_sel_i;
   logic [2:0]  funct3_i;
   logic [1:0]  addr_lo_i;
   logic [31:0] alu_i;
   logic [31:0] pc4_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        reg_wen_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;
   logic        retire_o;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic [31:0] rf_data1_i;
   logic [31:0] rf_data2_i;
   logic [31:0] data1_o;
   logic [31:0] data2_o;
   wb_state_e   state_o;

   int n_vec = 0;
   int n_err = 0;
   logic [36:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   wb_stage dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .rd_i          (rd_i),
      .reg_wen_i     (reg_wen_i),
      .wb_sel_i      (wb_sel_i),
      .funct3_i      (funct3_i),
      .addr_lo_i     (addr_lo_i),
      .alu_i         (alu_i),
      .pc4_i         (pc4_i),
      .dmem_rvalid_i (dmem_rvalid_i),
      .dmem_rdata_i  (dmem_rdata_i),
      .reg_wen_o     (reg_wen_o),
      .reg_waddr_o   (reg_waddr_o),
      .reg_wdata_o   (reg_wdata_o),
      .retire_o      (retire_o),
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .rf_data1_i    (rf_data1_i),
      .rf_data2_i    (rf_data2_i),
      .data1_o       (data1_o),
      .data2_o       (data2_o),
      .state_o       (state_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- scoreboard: every register write must be expected ----------------
   always @(negedge clk) begin
      if (!rst && reg_wen_o) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_write", {27'd0, reg_waddr_o}, 32'hffff_ffff);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("sb_waddr", {27'd0, reg_waddr_o}, {27'd0, e[36:32]});
            check("sb_wdata", reg_wdata_o, e[31:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic present(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                          input logic [2:0] f3, input logic [1:0] alo,
                          input logic [31:0] alu, input logic [31:0] pc4);
      valid_i   = 1'b1;
      rd_i      = rd;
      reg_wen_i = wen;
      wb_sel_i  = sel;
      funct3_i  = f3;
      addr_lo_i = alo;
      alu_i     = alu;
      pc4_i     = pc4;
   endtask

   task automatic expect_write(input logic [4:0] rd, input logic wen, input logic [31:0] data);
      if (wen && rd != 5'd0) exp_q.push_back({rd, data});
   endtask

   // Single non-load instruction; returns positioned at the idle negedge after WRITE.
   task automatic do_alu(input string tag, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] exp);
      @(negedge clk);
      check({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
      present(rd, 1'b1, sel, 3'd0, 2'd0, alu, pc4);
      expect_write(rd, 1'b1, exp);
      @(negedge clk);
      valid_i = 1'b0;
      check({tag, "_wen"},    {31'd0, reg_wen_o},   32'd1);
      check({tag, "_waddr"},  {27'd0, reg_waddr_o}, {27'd0, rd});
      check({tag, "_wdata"},  reg_wdata_o,          exp);
      check({tag, "_retire"}, {31'd0, retire_o},    32'd1);
      @(negedge clk);
      check({tag, "_idle_retire"}, {31'd0, retire_o}, 32'd0);
   endtask

   // Load with the response arriving lat cycles after the accept edge.
   task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] alo, input logic [31:0] word, input int lat,
                          input logic [31:0] exp);
      @(negedge clk);
      present(rd, 1'b1, WB_MEM, f3, alo, 32'h5555_5555, 32'h6666_6666);
      expect_write(rd, 1'b1, exp);
      @(negedge clk);
      valid_i = 1'b0;
      for (int i = 1; i <= lat; i++) begin
         check({tag, "_ready_low"}, {31'd0, ready_o},  32'd0);
         check({tag, "_no_retire"}, {31'd0, retire_o}, 32'd0);
         dmem_rvalid_i = (i == lat);
         dmem_rdata_i  = (i == lat) ? word : ~word;
         @(negedge clk);
      end
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = 32'hdead_beef;
      check({tag, "_ready"},  {31'd0, ready_o},     32'd1);
      check({tag, "_wen"},    {31'd0, reg_wen_o},   32'd1);
      check({tag, "_waddr"},  {27'd0, reg_waddr_o}, {27'd0, rd});
      check({tag, "_wdata"},  reg_wdata_o,          exp);
      check({tag, "_retire"}, {31'd0, retire_o},    32'd1);
   endtask

   // ---------------- directed sequence ----------------
   logic [31:0] bp_exp;

   initial begin
      rst = 1'b1;
      valid_i = 1'b0; rd_i = '0; reg_wen_i = 1'b0; wb_sel_i = '0; funct3_i = '0;
      addr_lo_i = '0; alu_i = '0; pc4_i = '0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      rs1_i = '0; rs2_i = '0; rf_data1_i = '0; rf_data2_i = '0;
      repeat (3) @(negedge clk);
      check("rst_ready",  {31'd0, ready_o},   32'd1);
      check("rst_wen",    {31'd0, reg_wen_o}, 32'd0);
      check("rst_retire", {31'd0, retire_o},  32'd0);
      check("rst_state",  {30'd0, state_o},   {30'd0, IDLE});
      rst = 1'b0;

      do_alu("alu",  5'd5,  WB_ALU, 32'h0000_1234, 32'h0000_0104, 32'h0000_1234);
      do_alu("pc4",  5'd9,  WB_PC4, 32'h0000_1111, 32'h0000_2008, 32'h0000_2008);
      do_alu("sel3", 5'd10, 2'd3,   32'h0bad_f00d, 32'h0000_3000, 32'h0bad_f00d);

      do_load("lb",   5'd3,  F3_LB,  2'd2, 32'h0080_0000, 3, 32'hffff_ff80);
      do_load("lbu",  5'd4,  F3_LBU, 2'd2, 32'h0080_0000, 3, 32'h0000_0080);
      do_load("lb3",  5'd6,  F3_LB,  2'd3, 32'h7f12_3456, 1, 32'h0000_007f);
      do_load("lh",   5'd7,  F3_LH,  2'd3, 32'h8001_1234, 2, 32'hffff_8001);
      do_load("lhu",  5'd8,  F3_LHU, 2'd1, 32'h8001_9234, 1, 32'h0000_9234);
      do_load("lw",   5'd11, F3_LW,  2'd0, 32'hcafe_babe, 1, 32'hcafe_babe);
      do_load("f3_3", 5'd12, 3'b011, 2'd1, 32'h1234_5678, 1, 32'h1234_5678);

      // rd = 0: retires but never writes
      @(negedge clk);
      present(5'd0, 1'b1, WB_ALU, 3'd0, 2'd0, 32'h0000_00ff, 32'd0);
      @(negedge clk);
      valid_i = 1'b0;
      check("rd0_wen",    {31'd0, reg_wen_o}, 32'd0);
      check("rd0_retire", {31'd0, retire_o},  32'd1);

      // three back-to-back ALU ops: one write per cycle, no bubble
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            check("b2b_wen",   {31'd0, reg_wen_o},   32'd1);
            check("b2b_waddr", {27'd0, reg_waddr_o}, 32'd20 + i - 1);
            check("b2b_wdata", reg_wdata_o,          32'h0000_a000 + i - 1);
         end
         if (i < 3) begin
            check("b2b_ready", {31'd0, ready_o}, 32'd1);
            present(5'd20 + 5'(i), 1'b1, WB_ALU, 3'd0, 2'd0, 32'h0000_a000 + i, 32'd0);
            expect_write(5'd20 + 5'(i), 1'b1, 32'h0000_a000 + i);
         end else begin
            valid_i = 1'b0;
         end
         @(negedge clk);
      end
      check("b2b_end_retire", {31'd0, retire_o}, 32'd0);

      // reset while waiting on a load: instruction dropped
      present(5'd13, 1'b1, WB_MEM, F3_LW, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      valid_i = 1'b0;
      check("rstw_in_wait", {31'd0, ready_o}, 32'd0);
      rst = 1'b1;
      #1;
      check("rstw_ready",  {31'd0, ready_o},     32'd1);
      check("rstw_wen",    {31'd0, reg_wen_o},   32'd0);
      check("rstw_waddr",  {27'd0, reg_waddr_o}, 32'd0);
      check("rstw_wdata",  reg_wdata_o,          32'd0);
      check("rstw_retire", {31'd0, retire_o},    32'd0);
      @(negedge clk);
      rst = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h1357_9bdf;
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
      check("rstw_post_wen",    {31'd0, reg_wen_o}, 32'd0);
      check("rstw_post_retire", {31'd0, retire_o},  32'd0);
      check("rstw_post_ready",  {31'd0, ready_o},   32'd1);
      check("rstw_post_state",  {30'd0, state_o},   {30'd0, IDLE});

      // read-port bypass during the WRITE cycle
`ifdef WB_BYPASS_EN
      bp_exp = 32'h0000_cafe;
`else
      bp_exp = 32'h0000_0000;
`endif
      @(negedge clk);
      present(5'd7, 1'b1, WB_ALU, 3'd0, 2'd0, 32'h0000_cafe, 32'd0);
      expect_write(5'd7, 1'b1, 32'h0000_cafe);
      @(negedge clk);
      valid_i = 1'b0;
      rs1_i = 5'd7; rs2_i = 5'd7; rf_data1_i = 32'd0; rf_data2_i = 32'd0;
      #1;
      check("bp_data1", data1_o, bp_exp);
      check("bp_data2", data2_o, bp_exp);
      @(negedge clk);
      present(5'd7, 1'b1, WB_ALU, 3'd0, 2'd0, 32'h0000_cafe, 32'd0);
      expect_write(5'd7, 1'b1, 32'h0000_cafe);
      rs1_i = 5'd0; rf_data1_i = 32'h0000_1111;
      #1;
      check("bp_idle_data2", data2_o, 32'd0);
      @(negedge clk);
      valid_i = 1'b0;
      #1;
      check("bp_rs0_data1", data1_o, 32'h0000_1111);
      check("bp_rs0_data2", data2_o, bp_exp);
      @(negedge clk);
      rs1_i = 5'd0; rs2_i = 5'd0; rf_data1_i = 32'd0;

      repeat (2) @(negedge clk);
      check("sb_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
